// File: rtl/conv_drv_pkg.sv
// Shared constants and types for the convolution stream driver.
//
// Holds the default geometry of the attached convolution core (vector
// length, filter length, word width), the derived result count, the
// positive saturation value of a result word and the driver state
// encoding. The interface and the top module import this package.
package conv_drv_pkg;

    localparam int DRV_N = 32;                  // input vector length (words)
    localparam int DRV_M = 10;                  // filter length of the core
    localparam int DRV_T = 16;                  // signed data word width
    localparam int DRV_L = DRV_N - DRV_M + 1;   // results produced per run

    // Largest positive result word; the core clips to this value on overflow.
    localparam logic signed [DRV_T-1:0] DRV_SAT = {1'b0, {(DRV_T-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_COLLECT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conv_stream_driver_if.sv
// Stream handshake bundle between the driver and the convolution core.
//
// Signals:
//   x_data  / x_valid / x_ready : input-vector stream, driver -> core
//   y_data  / y_valid / y_ready : result stream, core -> driver
// Modports:
//   master : the driver side (sources x, sinks y)
//   slave  : the core side (sinks x, sources y)
interface conv_stream_driver_if
    import conv_drv_pkg::*;
#(
    parameter int T = DRV_T
) ();

    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;

    modport master (
        output x_data,
        output x_valid,
        input  x_ready,
        input  y_data,
        input  y_valid,
        output y_ready
    );

    modport slave (
        input  x_data,
        input  x_valid,
        output x_ready,
        output y_data,
        output y_valid,
        input  y_ready
    );

endinterface

// File: rtl/conv_stream_driver_mem.sv
// Single-port-write / single-port-read synchronous memory.
//
// Ports:
//   clk      : clock, all activity on the rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled every cycle
//   o_rdata  : read data, valid one cycle after i_raddr
// A read and a write to the same address in one cycle return the word
// that was stored before the write. Contents are never reset.
module conv_stream_driver_mem #(
    parameter int DEPTH = 32,
    parameter int W     = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic signed [W-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic signed [W-1:0] o_rdata
);

    logic signed [W-1:0] r_mem [DEPTH];

    // Read and write share one process so the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/conv_stream_driver.sv
// Convolution stream driver.
//
// Holds an N-word input vector loaded by the host, streams it to an
// attached convolution core over a valid/ready handshake, collects the
// L = N-M+1 results into a readable buffer and reports how many results
// were zero and how many hit positive saturation.
//
// Ports:
//   clk       : clock (rising edge)
//   reset     : synchronous, active-low reset
//   ld_en     : host write strobe for the x buffer (honoured in IDLE/DONE)
//   ld_addr   : x buffer write address
//   ld_data   : x buffer write data
//   start     : one-cycle pulse starting a run (honoured in IDLE)
//   bus       : master side of the x/y stream interface
//   rd_addr   : result buffer read address
//   rd_data   : result word, one cycle after rd_addr
//   busy      : high while streaming or collecting
//   done      : one-cycle pulse when a run completes
//   zero_cnt  : number of zero results in the last run
//   sat_cnt   : number of saturated results in the last run
module conv_stream_driver
    import conv_drv_pkg::*;
#(
    parameter int N = DRV_N,
    parameter int M = DRV_M,
    parameter int T = DRV_T
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_en,
    input  logic [$clog2(N)-1:0]      ld_addr,
    input  logic signed [T-1:0]       ld_data,
    input  logic                      start,
    conv_stream_driver_if.master      bus,
    input  logic [$clog2(N-M+1)-1:0]  rd_addr,
    output logic signed [T-1:0]       rd_data,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N-M+1):0]    zero_cnt,
    output logic [$clog2(N-M+1):0]    sat_cnt
);

    localparam int L   = N - M + 1;
    localparam int AW  = $clog2(N);
    localparam int RAW = $clog2(L);
    localparam int CW  = RAW + 1;

    localparam logic signed [T-1:0] SAT_VAL = {1'b0, {(T-1){1'b1}}};

    function automatic logic f_is_zero(input logic signed [T-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic f_is_sat(input logic signed [T-1:0] v);
        return (v == SAT_VAL);
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_next;

    logic                w_send;
    logic                w_collect;
    logic                w_x_we;
    logic                w_start_run;

    logic [AW:0]         r_rd_ptr;      // next x buffer address to fetch
    logic [AW:0]         r_xfer_cnt;    // words handed to the core so far
    logic                r_inflight;    // x buffer read issued last cycle
    logic signed [T-1:0] r_x_data;      // presented word
    logic                r_x_valid;
    logic signed [T-1:0] r_skid;        // second word held while stalled
    logic                r_skid_vld;

    logic [RAW-1:0]      r_k;           // next result buffer address
    logic [CW-1:0]       r_zero_cnt;
    logic [CW-1:0]       r_sat_cnt;

    logic signed [T-1:0] w_x_rdata;
    logic                w_x_pop;
    logic                w_head_free;
    logic [1:0]          w_occ;
    logic                w_issue;
    logic                w_y_acc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_SEND;
            ST_SEND:    if (w_x_pop && (r_xfer_cnt == (AW+1)'(N-1))) w_next = ST_COLLECT;
            ST_COLLECT: if (w_y_acc && (r_k == RAW'(L-1))) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and state decodes
    // ------------------------------------------------------------------
    always_comb begin
        w_send      = 1'b0;
        w_collect   = 1'b0;
        done        = 1'b0;
        w_x_we      = 1'b0;
        w_start_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_x_we      = ld_en;
                w_start_run = start;
            end
            ST_SEND:    w_send    = 1'b1;
            ST_COLLECT: w_collect = 1'b1;
            ST_DONE: begin
                done   = 1'b1;
                w_x_we = ld_en;
            end
            default: ;
        endcase
        busy        = w_send | w_collect;
        bus.y_ready = w_collect;
    end

    // ------------------------------------------------------------------
    // Stage p0: x buffer fetch scheduling
    // ------------------------------------------------------------------
    // Up to two words are held on the output side (presented + skid).
    // A fetch is issued only if, counting the word already in flight,
    // there will still be room for it when it lands next cycle.
    assign w_x_pop     = r_x_valid & bus.x_ready;
    assign w_head_free = ~r_x_valid | w_x_pop;
    assign w_occ       = {1'b0, r_x_valid} + {1'b0, r_skid_vld}
                       + {1'b0, r_inflight} - {1'b0, w_x_pop};
    assign w_issue     = w_send && (r_rd_ptr < (AW+1)'(N)) && (w_occ < 2'd2);

    assign w_y_acc     = w_collect & bus.y_valid;

    conv_stream_driver_mem #(
        .DEPTH (N),
        .W     (T),
        .AW    (AW)
    ) u_x_mem (
        .clk     (clk),
        .i_we    (w_x_we),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_x_rdata)
    );

    // ------------------------------------------------------------------
    // Stage p1: output/skid registers and run counters (control)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_xfer_cnt <= '0;
            r_inflight <= 1'b0;
            r_x_valid  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_k        <= '0;
            r_zero_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (w_start_run) begin
            r_rd_ptr   <= '0;
            r_xfer_cnt <= '0;
            r_inflight <= 1'b0;
            r_x_valid  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_k        <= '0;
            r_zero_cnt <= '0;
            r_sat_cnt  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_x_pop) begin
                r_xfer_cnt <= r_xfer_cnt + (AW+1)'(1);
            end
            // Skid drains into the presented slot first, the landing word
            // fills whichever slot is left.
            if (w_head_free) begin
                r_x_valid  <= r_skid_vld | r_inflight;
                r_skid_vld <= r_skid_vld & r_inflight;
            end else if (r_inflight) begin
                r_skid_vld <= 1'b1;
            end
            if (w_y_acc) begin
                r_k <= r_k + RAW'(1);
                if (f_is_zero(bus.y_data)) r_zero_cnt <= r_zero_cnt + CW'(1);
                if (f_is_sat(bus.y_data))  r_sat_cnt  <= r_sat_cnt + CW'(1);
            end
        end
    end

    // Data side of the output/skid registers; no reset needed.
    always_ff @(posedge clk) begin
        if (w_head_free) begin
            if (r_skid_vld) begin
                r_x_data <= r_skid;
            end else if (r_inflight) begin
                r_x_data <= w_x_rdata;
            end
        end
        if (r_inflight && (!w_head_free || r_skid_vld)) begin
            r_skid <= w_x_rdata;
        end
    end

    assign bus.x_data  = r_x_data;
    assign bus.x_valid = r_x_valid;
    assign zero_cnt    = r_zero_cnt;
    assign sat_cnt     = r_sat_cnt;

    // ------------------------------------------------------------------
    // Stage p2: result buffer
    // ------------------------------------------------------------------
    conv_stream_driver_mem #(
        .DEPTH (L),
        .W     (T),
        .AW    (RAW)
    ) u_y_mem (
        .clk     (clk),
        .i_we    (w_y_acc),
        .i_waddr (r_k),
        .i_wdata (bus.y_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule

// File: tb/tb_conv_stream_driver.sv
// Testbench for conv_stream_driver with a behavioural 32-tap-input,
// 10-tap-filter convolution core whose coefficients sum to 271.
module tb_conv_stream_driver;

    localparam int N = 32;
    localparam int M = 10;
    localparam int T = 16;
    localparam int L = N - M + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                ld_en;
    logic [4:0]          ld_addr;
    logic signed [T-1:0] ld_data;
    logic                start;
    logic [4:0]          rd_addr;
    logic signed [T-1:0] rd_data;
    logic                busy;
    logic                done;
    logic [5:0]          zero_cnt;
    logic [5:0]          sat_cnt;

    always #5 clk = ~clk;

    conv_stream_driver_if #(.T(T)) bus ();

    conv_stream_driver #(.N(N), .M(M), .T(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .bus      (bus),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .zero_cnt (zero_cnt),
        .sat_cnt  (sat_cnt)
    );

    int coef [M] = '{10, 20, 25, 27, 30, 31, 32, 33, 31, 32};

    logic signed [T-1:0] xs  [N];
    logic signed [T-1:0] res [L];
    int n_xfer, stall_viol, done_pulses, n_acc, xv_collect;
    int n_checks = 0;
    int n_pass   = 0;

    // Core model: y[i] = sum c[j]*x[i+j], clipped to the signed 16-bit range.
    function automatic logic signed [T-1:0] core_y(input int i);
        longint acc;
        acc = 0;
        for (int j = 0; j < M; j++) acc += longint'(coef[j]) * longint'(xs[i+j]);
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return T'(acc);
    endfunction

    task automatic load_all(input logic signed [T-1:0] v);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 5'(i); ld_data = v;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic read_results();
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            rd_addr = 5'(k);
            @(negedge clk);
            res[k] = rd_data;
        end
    endtask

    // Starts a run and acts as the x sink; records every transfer.
    task automatic send_phase(input int drop_pct, input int abort_after, input bit inject,
                              input bit start_ld, input logic signed [T-1:0] ld_val);
        int cyc;
        bit prev_stall, rdy;
        logic signed [T-1:0] prev_data;
        cyc = 0; prev_stall = 1'b0; prev_data = '0; n_xfer = 0; stall_viol = 0;
        @(negedge clk);
        start = 1'b1;
        if (start_ld) begin
            ld_en = 1'b1; ld_addr = 5'd0; ld_data = ld_val;
        end
        @(negedge clk);
        while (n_xfer < N && cyc < 2000) begin
            start   = inject && (cyc == 5);
            ld_en   = inject && (cyc == 5);
            ld_addr = 5'd3;
            ld_data = 16'sd99;
            rdy = ($urandom_range(0, 99) >= drop_pct);
            bus.x_ready = rdy;
            if (prev_stall && (bus.x_valid !== 1'b1 || bus.x_data !== prev_data)) stall_viol++;
            prev_stall = 1'b0;
            if (bus.x_valid === 1'b1) begin
                if (rdy) begin
                    xs[n_xfer] = bus.x_data;
                    n_xfer++;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = bus.x_data;
                end
            end
            if (abort_after > 0 && n_xfer == abort_after) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ld_en = 1'b0;
    endtask

    // Acts as the y source; counts accepted words and done pulses.
    task automatic collect_phase(input int gap_pct);
        int cyc;
        cyc = 0; n_acc = 0; done_pulses = 0; xv_collect = 0;
        @(negedge clk);
        bus.x_ready = 1'b0;
        while (n_acc < L && cyc < 1000) begin
            if (done === 1'b1) done_pulses++;
            if (bus.x_valid !== 1'b0) xv_collect++;
            if (bus.y_ready === 1'b1 && $urandom_range(0, 99) >= gap_pct) begin
                bus.y_valid = 1'b1;
                bus.y_data  = core_y(n_acc);
                n_acc++;
            end else begin
                bus.y_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.y_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) done_pulses++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (bus.x_valid !== 1'b0) $display("FAIL rst_xvalid: got %b expected 0", bus.x_valid); else n_pass++;
        n_checks++; if (bus.y_ready !== 1'b0) $display("FAIL rst_yready: got %b expected 0", bus.y_ready); else n_pass++;
        n_checks++; if (zero_cnt !== 6'd0) $display("FAIL rst_zero_cnt: got %0d expected 0", zero_cnt); else n_pass++;
        n_checks++; if (sat_cnt !== 6'd0) $display("FAIL rst_sat_cnt: got %0d expected 0", sat_cnt); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones();
        load_all(16'sd1);
        send_phase(0, 0, 1'b0, 1'b0, '0);
        collect_phase(0);
        read_results();
        n_checks++; if (n_xfer !== 32) $display("FAIL ones_xfers: got %0d expected 32", n_xfer); else n_pass++;
        n_checks++; if (n_acc !== 23) $display("FAIL ones_accepted: got %0d expected 23", n_acc); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL ones_done_pulses: got %0d expected 1", done_pulses); else n_pass++;
        n_checks++; if (xv_collect !== 0) $display("FAIL ones_xvalid_in_collect: got %0d cycles expected 0", xv_collect); else n_pass++;
        for (int k = 0; k < L; k++) begin
            n_checks++;
            if (res[k] !== 16'sd271) $display("FAIL ones_result[%0d]: got %0d expected 271", k, res[k]); else n_pass++;
        end
        n_checks++; if (zero_cnt !== 6'd0) $display("FAIL ones_zero_cnt: got %0d expected 0", zero_cnt); else n_pass++;
        n_checks++; if (sat_cnt !== 6'd0) $display("FAIL ones_sat_cnt: got %0d expected 0", sat_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ones_busy_after: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_y_outside_collect();
        @(negedge clk);
        bus.y_valid = 1'b1;
        bus.y_data  = 16'sd0;
        @(negedge clk);
        n_checks++; if (bus.y_ready !== 1'b0) $display("FAIL idle_yready: got %b expected 0", bus.y_ready); else n_pass++;
        repeat (3) @(negedge clk);
        bus.y_valid = 1'b0;
        read_results();
        n_checks++; if (zero_cnt !== 6'd0) $display("FAIL idle_y_zero_cnt: got %0d expected 0", zero_cnt); else n_pass++;
        n_checks++; if (res[0] !== 16'sd271) $display("FAIL idle_y_result0: got %0d expected 271", res[0]); else n_pass++;
    endtask

    task automatic test_zeros();
        load_all(16'sd0);
        send_phase(0, 0, 1'b0, 1'b0, '0);
        collect_phase(0);
        read_results();
        for (int k = 0; k < L; k++) begin
            n_checks++;
            if (res[k] !== 16'sd0) $display("FAIL zeros_result[%0d]: got %0d expected 0", k, res[k]); else n_pass++;
        end
        n_checks++; if (zero_cnt !== 6'd23) $display("FAIL zeros_zero_cnt: got %0d expected 23", zero_cnt); else n_pass++;
        n_checks++; if (sat_cnt !== 6'd0) $display("FAIL zeros_sat_cnt: got %0d expected 0", sat_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        load_all(16'sd1);
        send_phase(30, 0, 1'b0, 1'b0, '0);
        collect_phase(30);
        read_results();
        n_checks++; if (n_xfer !== 32) $display("FAIL stall_xfers: got %0d expected 32", n_xfer); else n_pass++;
        n_checks++; if (stall_viol !== 0) $display("FAIL stall_stability: got %0d unstable cycles expected 0", stall_viol); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL stall_done_pulses: got %0d expected 1", done_pulses); else n_pass++;
        for (int k = 0; k < L; k++) begin
            n_checks++;
            if (res[k] !== 16'sd271) $display("FAIL stall_result[%0d]: got %0d expected 271", k, res[k]); else n_pass++;
        end
        n_checks++; if (zero_cnt !== 6'd0) $display("FAIL stall_zero_cnt_cleared: got %0d expected 0", zero_cnt); else n_pass++;
    endtask

    task automatic test_ignored_in_send();
        int bad;
        send_phase(0, 0, 1'b1, 1'b0, '0);
        collect_phase(0);
        bad = 0;
        for (int i = 0; i < N; i++) if (xs[i] !== 16'sd1) bad++;
        n_checks++; if (bad !== 0) $display("FAIL ign_streamed_words: got %0d wrong words expected 0", bad); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL ign_done_pulses: got %0d expected 1", done_pulses); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_restart: got busy %b expected 0", busy); else n_pass++;
        send_phase(0, 0, 1'b0, 1'b0, '0);
        collect_phase(0);
        n_checks++; if (xs[3] !== 16'sd1) $display("FAIL ign_xbuf_word3: got %0d expected 1", xs[3]); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        send_phase(0, 10, 1'b0, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        bus.x_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (bus.x_valid !== 1'b0) $display("FAIL midrst_xvalid: got %b expected 0", bus.x_valid); else n_pass++;
        send_phase(0, 0, 1'b0, 1'b0, '0);
        collect_phase(0);
        read_results();
        n_checks++; if (n_xfer !== 32) $display("FAIL midrst_xfers: got %0d expected 32", n_xfer); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL midrst_done_pulses: got %0d expected 1", done_pulses); else n_pass++;
        n_checks++; if (res[0] !== 16'sd271) $display("FAIL midrst_result0: got %0d expected 271", res[0]); else n_pass++;
        n_checks++; if (res[22] !== 16'sd271) $display("FAIL midrst_result22: got %0d expected 271", res[22]); else n_pass++;
    endtask

    task automatic test_start_with_load();
        send_phase(0, 0, 1'b0, 1'b1, 16'sd7);
        collect_phase(0);
        read_results();
        n_checks++; if (xs[0] !== 16'sd7) $display("FAIL stld_word0: got %0d expected 7", xs[0]); else n_pass++;
        n_checks++; if (res[0] !== 16'sd331) $display("FAIL stld_result0: got %0d expected 331", res[0]); else n_pass++;
        n_checks++; if (res[1] !== 16'sd271) $display("FAIL stld_result1: got %0d expected 271", res[1]); else n_pass++;
    endtask

    task automatic test_saturation();
        load_all(16'sd200);
        send_phase(0, 0, 1'b0, 1'b0, '0);
        collect_phase(0);
        read_results();
        n_checks++; if (sat_cnt !== 6'd23) $display("FAIL sat_sat_cnt: got %0d expected 23", sat_cnt); else n_pass++;
        n_checks++; if (zero_cnt !== 6'd0) $display("FAIL sat_zero_cnt: got %0d expected 0", zero_cnt); else n_pass++;
        n_checks++; if (res[0] !== 16'sd32767) $display("FAIL sat_result0: got %0d expected 32767", res[0]); else n_pass++;
        n_checks++; if (res[22] !== 16'sd32767) $display("FAIL sat_result22: got %0d expected 32767", res[22]); else n_pass++;
    endtask

    initial begin
        reset       = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        start       = 1'b0;
        rd_addr     = '0;
        bus.x_ready = 1'b0;
        bus.y_valid = 1'b0;
        bus.y_data  = '0;

        test_reset();
        test_ones();
        test_y_outside_collect();
        test_zeros();
        test_stall();
        test_ignored_in_send();
        test_reset_mid_run();
        test_start_with_load();
        test_saturation();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_stream_driver.md
CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

Interface
REQ-001 Parameter N, default 32: input vector length, in words.
REQ-002 Parameter M, default 10: filter length of the attached convolution core.
REQ-003 Parameter T, default 16: data word width, signed.
REQ-004 Localparam L = N-M+1: number of results expected per run.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 ld_en  input  1  host writes ld_data into the x buffer at ld_addr.
REQ-008 ld_addr  input  clog2(N)  x buffer write address.
REQ-009 ld_data  input  T  signed x word to store.
REQ-010 start  input  1  one-cycle pulse that begins a run.
REQ-011 x_data  output  T  stream word to the core.
REQ-012 x_valid  output  1  x_data is valid.
REQ-013 x_ready  input  1  core accepts x_data.
REQ-014 y_data  input  T  result word from the core.
REQ-015 y_valid  input  1  y_data is valid.
REQ-016 y_ready  output  1  driver accepts y_data.
REQ-017 rd_addr  input  clog2(L)  result buffer read address.
REQ-018 rd_data  output  T  result word; 1-cycle synchronous read latency.
REQ-019 busy  output  1  high in SEND and COLLECT.
REQ-020 done  output  1  one-cycle pulse when a run completes.
REQ-021 zero_cnt  output  clog2(L)+1  count of results equal to 0 in the last run.
REQ-022 sat_cnt  output  clog2(L)+1  count of results equal to 2^(T-1)-1 in the last run.

Function
REQ-023 The FSM SHALL have states IDLE, SEND, COLLECT and DONE.
REQ-024 IDLE -> SEND on start=1; start SHALL be ignored in every other state.
REQ-025 SEND SHALL stream x buffer words 0..N-1 in order; one word transfers per cycle in which x_valid=1 and x_ready=1.
REQ-026 x_valid SHALL rise no earlier than 1 cycle after entering SEND, because the x buffer read is synchronous.
REQ-027 While x_valid=1 and x_ready=0, x_data and x_valid SHALL hold stable; a prefetch/skid register sustains 1 word per cycle under continuous x_ready.
REQ-028 SEND -> COLLECT in the cycle after the Nth transfer; x_valid SHALL be 0 in COLLECT.
REQ-029 In COLLECT, y_ready SHALL be 1; each y_valid=1 cycle writes y_data to result buffer address k (k = 0..L-1) and increments k.
REQ-030 Each accepted y word SHALL increment zero_cnt if it equals 0, and sat_cnt if it equals 2^(T-1)-1.
REQ-031 COLLECT -> DONE after the Lth accepted word; done SHALL pulse for the single cycle spent in DONE; DONE -> IDLE unconditionally.
REQ-032 y_valid outside COLLECT SHALL NOT be accepted; y_ready SHALL be 0 outside COLLECT.
REQ-033 ld_en SHALL write only in IDLE or DONE and SHALL be ignored while busy=1.
REQ-034 zero_cnt and sat_cnt SHALL clear on entering SEND and hold their values after DONE until the next start.
REQ-035 The result buffer SHALL stay readable in every state; a read and a write to the same address in one cycle returns the old word.
REQ-036 A start pulse coincident with ld_en in IDLE SHALL apply the write and begin SEND; that word is the one streamed.

Reset
REQ-037 reset=0 SHALL force IDLE, x_valid=0, y_ready=0, busy=0, done=0, zero_cnt=0, sat_cnt=0, and all counters to 0, including mid-run; buffer contents are not reset.

Structure
REQ-038 Package conv_drv_pkg SHALL hold N, M, T, L, the saturation constant and the state enum.
REQ-039 The x and result buffers SHALL each be an instance of the team's existing memory module (synchronous read, write enable); no other sub-modules.

Verification
REQ-040 Connect to conv_32_10_16_1 and load x=1 for all 32 words, then start -> 23 results of 271, zero_cnt=0, sat_cnt=0, and done pulses once.
REQ-041 Load x=0 for all words and run -> all results 0, zero_cnt=23.
REQ-042 Randomly drop x_ready for 30% of cycles -> x_data stable while stalled, exactly 32 transfers, results identical to REQ-040.
REQ-043 Pulse start again and assert ld_en during SEND -> both ignored, and the x buffer is unchanged.
REQ-044 Drive reset=0 for 1 cycle after 10 transfers -> IDLE next cycle, x_valid=0; a fresh start completes a correct run.
REQ-045 Load x=200 for all words -> sat_cnt matches the golden-model count of results equal to 32767.
